// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan controller for a common-cathode 7-segment display.
// One shared BCD decoder; new display values commit only at frame boundaries.
module seg7_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int PRESCALE     = 1000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    lzb_en,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [4*NUM_DIGITS-1:0] load_data,
  input  logic [NUM_DIGITS-1:0]   load_dp,
  output logic [3:0]              bcd_out,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic                    dp_out,
  output logic                    frame_done,
  output logic                    bcd_err
);
  localparam int W  = 4*NUM_DIGITS;
  localparam int CW = $clog2(PRESCALE);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES-1);
  localparam logic [CW-1:0] SLOT_LAST  = CW'(PRESCALE-1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS-1);

  typedef enum logic [1:0] {IDLE = 2'd0, BLANK = 2'd1, SHOW = 2'd2} state_t;

  state_t                state, state_nxt;
  logic [CW-1:0]         cnt, cnt_nxt;
  logic [IW-1:0]         idx, idx_nxt;
  logic                  pending;
  logic [W-1:0]          active, shadow, active_nxt;
  logic [NUM_DIGITS-1:0] active_dp, shadow_dp, active_dp_nxt;
  logic                  take, commit;

  function automatic logic [3:0] nibble_at(input logic [W-1:0] word, input int i);
    return word[4*i +: 4];
  endfunction

  function automatic logic has_bad_nibble(input logic [W-1:0] word);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (nibble_at(word, i) > 4'd9) bad = 1'b1;
    return bad;
  endfunction

  // Dark slot for a non-BCD nibble, or for a leading zero (digit 0 always lit).
  function automatic logic suppressed(input logic [W-1:0] word, input int i,
                                      input logic lzb);
    logic sup;
    logic upper_zero;
    sup = (nibble_at(word, i) > 4'd9);
    if (lzb && i != 0) begin
      upper_zero = 1'b1;
      for (int j = 0; j < NUM_DIGITS; j++)
        if (j >= i && nibble_at(word, j) != 4'd0) upper_zero = 1'b0;
      if (upper_zero) sup = 1'b1;
    end
    return sup;
  endfunction

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    idx_nxt    = idx;
    frame_done = 1'b0;
    case (state)
      IDLE: begin
        if (enable) begin
          state_nxt = BLANK;
          cnt_nxt   = '0;
          idx_nxt   = '0;
        end
      end
      BLANK: begin
        if (cnt == BLANK_LAST) state_nxt = SHOW;
        cnt_nxt = cnt + CW'(1);
      end
      SHOW: begin
        if (cnt == SLOT_LAST) begin
          cnt_nxt   = '0;
          state_nxt = BLANK;
          if (idx == IDX_LAST) begin
            idx_nxt    = '0;
            frame_done = 1'b1;
          end else begin
            idx_nxt = idx + IW'(1);
          end
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (!enable) begin
      state_nxt  = IDLE;
      cnt_nxt    = '0;
      idx_nxt    = '0;
      frame_done = 1'b0;
    end
  end

  // Commit at a frame boundary, or immediately while the scan is idle.
  assign take          = load_valid & load_ready;
  assign commit        = pending & (frame_done | (state == IDLE));
  assign active_nxt    = commit ? shadow    : active;
  assign active_dp_nxt = commit ? shadow_dp : active_dp;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      idx        <= '0;
      pending    <= 1'b0;
      load_ready <= 1'b1;
      active     <= '0;
      active_dp  <= '0;
      shadow     <= '0;
      shadow_dp  <= '0;
      bcd_out    <= 4'd0;
      dp_out     <= 1'b0;
      digit_en   <= '0;
      bcd_err    <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      idx       <= idx_nxt;
      active    <= active_nxt;
      active_dp <= active_dp_nxt;
      if (take) begin
        shadow    <= load_data;
        shadow_dp <= load_dp;
      end
      if (take)        pending <= 1'b1;
      else if (commit) pending <= 1'b0;
      load_ready <= ~(take | (pending & ~commit));
      if (commit && has_bad_nibble(shadow)) bcd_err <= 1'b1;
      // Segment data only moves on slot entry, while every digit is dark.
      if (state_nxt == BLANK && state != BLANK) begin
        bcd_out <= nibble_at(active_nxt, int'(idx_nxt));
        dp_out  <= active_dp_nxt[idx_nxt];
      end
      if (state_nxt == SHOW && !suppressed(active_nxt, int'(idx_nxt), lzb_en))
        digit_en <= NUM_DIGITS'(1) << idx_nxt;
      else
        digit_en <= '0;
    end
  end
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with 4 digits, 4-cycle slots, 1 blank cycle.
module tb_seg7_scan_ctrl;
  logic        clk = 1'b0;
  logic        rst_n, enable, lzb_en, load_valid, load_ready;
  logic [15:0] load_data;
  logic [3:0]  load_dp, bcd_out, digit_en;
  logic        dp_out, frame_done, bcd_err;
  int          vectors = 0;
  int          miscompares = 0;

  always #5 clk = ~clk;

  seg7_scan_ctrl #(.NUM_DIGITS(4), .PRESCALE(4), .BLANK_CYCLES(1)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .lzb_en(lzb_en),
    .load_valid(load_valid), .load_ready(load_ready), .load_data(load_data),
    .load_dp(load_dp), .bcd_out(bcd_out), .digit_en(digit_en), .dp_out(dp_out),
    .frame_done(frame_done), .bcd_err(bcd_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // k = cycle within frame; slot k/4 has one blank cycle then three lit cycles.
  task automatic check_cycle(input string f, input int k, input logic [15:0] disp,
                             input logic [3:0] lit, input logic [3:0] dpm);
    int s;
    logic [3:0] exp_en;
    s = k / 4;
    exp_en = ((k % 4) == 0 || !lit[s]) ? 4'b0000 : 4'(1 << s);
    chk($sformatf("%s.k%0d.digit_en", f, k), 32'(digit_en), 32'(exp_en));
    chk($sformatf("%s.k%0d.bcd_out", f, k), 32'(bcd_out), 32'(disp[4*s +: 4]));
    chk($sformatf("%s.k%0d.dp_out", f, k), 32'(dp_out), 32'(dpm[s]));
    chk($sformatf("%s.k%0d.frame_done", f, k), 32'(frame_done), 32'(k == 15));
  endtask

  task automatic check_reset(input string f);
    chk({f, ".digit_en"}, 32'(digit_en), 32'h0);
    chk({f, ".bcd_out"}, 32'(bcd_out), 32'h0);
    chk({f, ".dp_out"}, 32'(dp_out), 32'h0);
    chk({f, ".frame_done"}, 32'(frame_done), 32'h0);
    chk({f, ".bcd_err"}, 32'(bcd_err), 32'h0);
    chk({f, ".load_ready"}, 32'(load_ready), 32'h1);
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; lzb_en = 1'b0;
    load_valid = 1'b0; load_data = 16'h0; load_dp = 4'h0;
    tick(2);
    check_reset("reset");

    rst_n = 1'b1; load_valid = 1'b1; load_data = 16'h1234; load_dp = 4'b0100;
    tick();
    chk("idle_accept.load_ready", 32'(load_ready), 32'h0);
    load_valid = 1'b0;
    tick();
    chk("idle_commit.load_ready", 32'(load_ready), 32'h1);
    enable = 1'b1;
    tick();

    for (int k = 0; k < 16; k++) begin
      check_cycle("f1", k, 16'h1234, 4'b1111, 4'b0100);
      tick();
    end

    chk("f2.bcd_err", 32'(bcd_err), 32'h0);
    for (int k = 0; k < 16; k++) begin
      check_cycle("f2", k, 16'h1234, 4'b1111, 4'b0100);
      if (k >= 6) chk($sformatf("f2.k%0d.load_ready", k), 32'(load_ready), 32'h0);
      if (k == 5) begin
        load_valid = 1'b1; load_data = 16'h5678; load_dp = 4'b0001;
      end
      if (k == 6) load_valid = 1'b0;
      tick();
    end

    chk("f3.load_ready", 32'(load_ready), 32'h1);
    lzb_en = 1'b1;
    for (int k = 0; k < 16; k++) begin
      check_cycle("f3", k, 16'h5678, 4'b1111, 4'b0001);
      if (k == 0) begin
        load_valid = 1'b1; load_data = 16'h0070; load_dp = 4'b0000;
      end
      if (k == 1) begin
        chk("f3.held.load_ready", 32'(load_ready), 32'h0);
        load_data = 16'h0000; load_dp = 4'b1000;
      end
      tick();
    end

    chk("f4.load_ready", 32'(load_ready), 32'h1);
    for (int k = 0; k < 16; k++) begin
      check_cycle("f4", k, 16'h0070, 4'b0011, 4'b0000);
      if (k == 1) begin
        chk("f4.second.load_ready", 32'(load_ready), 32'h0);
        load_valid = 1'b0;
      end
      tick();
    end

    chk("f5.load_ready", 32'(load_ready), 32'h1);
    for (int k = 0; k < 16; k++) begin
      check_cycle("f5", k, 16'h0000, 4'b0001, 4'b1000);
      if (k == 0) begin
        load_valid = 1'b1; load_data = 16'h12A4; load_dp = 4'b0000;
      end
      if (k == 1) load_valid = 1'b0;
      if (k == 15) chk("f5.bcd_err", 32'(bcd_err), 32'h0);
      tick();
    end

    chk("f6.bcd_err", 32'(bcd_err), 32'h1);
    for (int k = 0; k < 10; k++) begin
      check_cycle("f6", k, 16'h12A4, 4'b1101, 4'b0000);
      if (k == 9) enable = 1'b0;
      tick();
    end
    chk("disable.digit_en", 32'(digit_en), 32'h0);
    chk("disable.frame_done", 32'(frame_done), 32'h0);
    tick(3);
    chk("idle.digit_en", 32'(digit_en), 32'h0);
    chk("idle.bcd_err", 32'(bcd_err), 32'h1);
    enable = 1'b1;
    tick();

    for (int k = 0; k < 16; k++) begin
      check_cycle("f7", k, 16'h12A4, 4'b1101, 4'b0000);
      tick();
    end

    load_valid = 1'b1; load_data = 16'h9999; load_dp = 4'b1111;
    tick();
    chk("pend.load_ready", 32'(load_ready), 32'h0);
    load_valid = 1'b0; rst_n = 1'b0; enable = 1'b0;
    tick();
    check_reset("midrst");
    rst_n = 1'b1;
    tick(2);
    enable = 1'b1;
    tick();
    chk("post_rst.bcd_out", 32'(bcd_out), 32'h0);
    chk("post_rst.dp_out", 32'(dp_out), 32'h0);
    chk("post_rst.digit_en0", 32'(digit_en), 32'h0);
    tick();
    chk("post_rst.digit_en1", 32'(digit_en), 32'h1);
    tick(4);
    chk("post_rst.digit_en5", 32'(digit_en), 32'h0);
    chk("post_rst.load_ready", 32'(load_ready), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
